// File: rtl/quadrature_decoder.sv
// Quadrature decoder: synchronizes the A/B channels, optionally debounces them,
// and turns each accepted phase change into a single up or down pulse.
// A double step (two Gray positions at once) raises the sticky err flag instead.
// Optional feature macro: QDEC_FILTER_EN. It enables a per-channel stability
// filter of FILTER_LEN cycles. When the macro is undefined, FILTER_LEN is ignored.
module quadrature_decoder #(
    parameter int unsigned FILTER_LEN  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic a_in,
    input  logic b_in,
    input  logic err_clr,
    output logic up,
    output logic down,
    output logic dir,
    output logic err
);

    localparam int unsigned FILL_W = 3;
    localparam int unsigned CNT_W  = 8;

    // Elaboration-time parameter range checks
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("quadrature_decoder: SYNC_STAGES must be 2..4");
    end
    if (FILTER_LEN < 1 || FILTER_LEN > 255) begin : g_bad_filter
        $error("quadrature_decoder: FILTER_LEN must be 1..255");
    end

    logic [SYNC_STAGES-1:0] a_sync_q;
    logic [SYNC_STAGES-1:0] b_sync_q;
    logic                   a_s;
    logic                   b_s;
    logic [FILL_W-1:0]      fill_q;
    logic                   sync_full;
    logic [1:0]             phase;
    logic                   phase_vld;

    // Per-channel synchronizer chains
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sync_q <= '0;
            b_sync_q <= '0;
        end else begin
            a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], a_in};
            b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], b_in};
        end
    end

    assign a_s = a_sync_q[SYNC_STAGES-1];
    assign b_s = b_sync_q[SYNC_STAGES-1];

    // Counts reset-cleared stages out of the chain so the first real pin level is recognised
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_q <= '0;
        end else if (!sync_full) begin
            fill_q <= fill_q + FILL_W'(1);
        end
    end

    assign sync_full = (fill_q == FILL_W'(SYNC_STAGES));

`ifdef QDEC_FILTER_EN
    logic [1:0]            lvl_s;
    logic [1:0]            cand_q,    cand_d;
    logic [1:0]            acc_q,     acc_d;
    logic [1:0]            acc_vld_q, acc_vld_d;
    logic [1:0][CNT_W-1:0] cnt_q,     cnt_d;

    assign lvl_s = {a_s, b_s};

    // Stability filter: a channel level is accepted after FILTER_LEN identical samples
    always_comb begin
        cand_d    = cand_q;
        acc_d     = acc_q;
        acc_vld_d = acc_vld_q;
        cnt_d     = cnt_q;
        if (sync_full) begin
            for (int ch = 0; ch < 2; ch++) begin
                if (lvl_s[ch] != cand_q[ch]) begin
                    cand_d[ch] = lvl_s[ch];
                    cnt_d[ch]  = CNT_W'(1);
                end else if (cnt_q[ch] != CNT_W'(FILTER_LEN)) begin
                    cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
                end
                if (cnt_d[ch] == CNT_W'(FILTER_LEN)) begin
                    acc_d[ch]     = lvl_s[ch];
                    acc_vld_d[ch] = 1'b1;
                end
            end
        end
    end

    // Filter state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cand_q    <= '0;
            acc_q     <= '0;
            acc_vld_q <= '0;
            cnt_q     <= '0;
        end else begin
            cand_q    <= cand_d;
            acc_q     <= acc_d;
            acc_vld_q <= acc_vld_d;
            cnt_q     <= cnt_d;
        end
    end

    assign phase     = acc_q;
    assign phase_vld = &acc_vld_q;
`else
    assign phase     = {a_s, b_s};
    assign phase_vld = sync_full;
`endif

    logic [1:0] prev_q, prev_d;
    logic       prev_vld_q, prev_vld_d;
    logic       up_q, up_d;
    logic       down_q, down_d;
    logic       dir_q, dir_d;
    logic       err_q, err_d;
    logic [1:0] prev_idx;
    logic [1:0] new_idx;
    logic [1:0] delta;

    // Gray phase to position: 00->0, 01->1, 11->2, 10->3
    assign prev_idx = {prev_q[1], prev_q[1] ^ prev_q[0]};
    assign new_idx  = {phase[1], phase[1] ^ phase[0]};
    assign delta    = new_idx - prev_idx;

    // Step classification against the previous accepted phase
    always_comb begin
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        up_d       = 1'b0;
        down_d     = 1'b0;
        dir_d      = dir_q;
        err_d      = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (phase_vld) begin
            if (!prev_vld_q) begin
                prev_d     = phase;
                prev_vld_d = 1'b1;
            end else if (phase != prev_q) begin
                prev_d = phase;
                if (enable) begin
                    unique case (delta)
                        2'd1: begin
                            up_d  = 1'b1;
                            dir_d = 1'b1;
                        end
                        2'd3: begin
                            down_d = 1'b1;
                            dir_d  = 1'b0;
                        end
                        2'd2:    err_d = 1'b1;
                        default: ;
                    endcase
                end
            end
        end
    end

    // Decoder state and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            up_q       <= 1'b0;
            down_q     <= 1'b0;
            dir_q      <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            up_q       <= up_d;
            down_q     <= down_d;
            dir_q      <= dir_d;
            err_q      <= err_d;
        end
    end

    assign up   = up_q;
    assign down = down_q;
    assign dir  = dir_q;
    assign err  = err_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Directed bench for quadrature_decoder with a pulse scoreboard.
module tb_quadrature_decoder;

`ifdef QDEC_FILTER_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 3;
`endif
    localparam int HOLD = 10;
    localparam int KIND_NONE = 0;
    localparam int KIND_UP   = 1;
    localparam int KIND_DOWN = 2;

    typedef struct {
        int kind;
        int due;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic a_in;
    logic b_in;
    logic err_clr;
    logic up;
    logic down;
    logic dir;
    logic err;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    quadrature_decoder dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .a_in    (a_in),
        .b_in    (b_in),
        .err_clr (err_clr),
        .up      (up),
        .down    (down),
        .dir     (dir),
        .err     (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One cycle: sample at the falling edge and reconcile pulses with the scoreboard
    task automatic sample();
        exp_t e;
        @(negedge clk);
        if (up === 1'b1 || down === 1'b1) begin
            check("unexpected_pulse", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("pulse_kind", (up === 1'b1) ? 1 : 2, e.kind);
                check("pulse_cycle", cyc, e.due);
            end
        end
        check("up_down_excl", 32'(up & down), 0);
        check("missed_pulse", 32'(sb.size() != 0 && sb[0].due < cyc), 0);
        if (sb.size() != 0 && sb[0].due < cyc) void'(sb.pop_front());
    endtask

    task automatic step(input logic a, input logic b, input int kind, input int hold);
        a_in = a;
        b_in = b;
        if (kind != KIND_NONE) sb.push_back('{kind, cyc + LAT});
        repeat (hold) sample();
    endtask

    initial begin
        reset   = 1'b1;
        enable  = 1'b1;
        a_in    = 1'b0;
        b_in    = 1'b0;
        err_clr = 1'b0;
        repeat (3) sample();
        check("rst_up", up, 0);
        check("rst_down", down, 0);
        check("rst_dir", dir, 1);
        check("rst_err", err, 0);
        reset = 1'b0;
        step(1'b0, 1'b0, KIND_NONE, HOLD);

        // Forward sequence
        step(1'b0, 1'b1, KIND_UP, HOLD);
        step(1'b1, 1'b1, KIND_UP, HOLD);
        step(1'b1, 1'b0, KIND_UP, HOLD);
        step(1'b0, 1'b0, KIND_UP, HOLD);
        check("fwd_dir", dir, 1);
        check("fwd_err", err, 0);

        // Reverse sequence
        step(1'b1, 1'b0, KIND_DOWN, HOLD);
        check("rev_dir_first", dir, 0);
        step(1'b1, 1'b1, KIND_DOWN, HOLD);
        step(1'b0, 1'b1, KIND_DOWN, HOLD);
        step(1'b0, 1'b0, KIND_DOWN, HOLD);
        check("rev_dir", dir, 0);
        check("rev_err", err, 0);

        // Illegal jump 00->11
        step(1'b1, 1'b1, KIND_NONE, HOLD);
        check("jump_err", err, 1);
        check("jump_dir_hold", dir, 0);
        err_clr = 1'b1;
        sample();
        err_clr = 1'b0;
        check("err_clr", err, 0);

        // Illegal jump 11->00 coincident with err_clr: set wins
        a_in = 1'b0;
        b_in = 1'b0;
        repeat (LAT - 1) sample();
        err_clr = 1'b1;
        sample();
        err_clr = 1'b0;
        check("set_wins", err, 1);
        repeat (HOLD) sample();
        check("set_wins_sticky", err, 1);
        err_clr = 1'b1;
        sample();
        err_clr = 1'b0;
        check("err_clr2", err, 0);

        // Silent tracking with enable low, then one enabled forward step
        enable = 1'b0;
        step(1'b0, 1'b1, KIND_NONE, HOLD);
        step(1'b1, 1'b1, KIND_NONE, HOLD);
        check("dis_dir_hold", dir, 0);
        check("dis_err", err, 0);
        enable = 1'b1;
        step(1'b1, 1'b0, KIND_UP, HOLD);
        check("en_dir", dir, 1);

        // Reset mid-operation aborts the pending pulse (10->00 would be forward)
        a_in = 1'b0;
        b_in = 1'b0;
        repeat (LAT - 1) sample();
        reset = 1'b1;
        repeat (2) sample();
        reset = 1'b0;
        repeat (HOLD + 4) sample();
        check("abort_dir", dir, 1);
        check("abort_err", err, 0);

        // Inputs at 11 through reset release: first phase loads silently
        a_in  = 1'b1;
        b_in  = 1'b1;
        reset = 1'b1;
        repeat (3) sample();
        reset = 1'b0;
        repeat (HOLD + 4) sample();
        check("rst11_err", err, 0);
        step(1'b1, 1'b0, KIND_UP, HOLD);
        check("rst11_dir", dir, 1);

`ifdef QDEC_FILTER_EN
        // Two-cycle glitch on a_in is rejected, a held change is accepted
        a_in = 1'b0;
        repeat (2) sample();
        a_in = 1'b1;
        repeat (HOLD + 4) sample();
        check("glitch_err", err, 0);
        step(1'b0, 1'b0, KIND_UP, HOLD);
`endif

        repeat (4) sample();
        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/quadrature_decoder.md
QUADRATURE_DECODER -- requirements
Module: quadrature_decoder

Interface
REQ-001 Parameter FILTER_LEN, default 4: consecutive stable cycles required to accept an input level; legal range 1..255; used only when QDEC_FILTER_EN is defined.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flop depth per input; legal range 2..4.
REQ-003 clk  input  1  single clock; all state is updated on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  high = emit up/down pulses and detect errors; low = track phase silently.
REQ-006 a_in  input  1  quadrature channel A; asynchronous to clk.
REQ-007 b_in  input  1  quadrature channel B; asynchronous to clk.
REQ-008 err_clr  input  1  synchronous clear of err.
REQ-009 up  output  1  one-cycle pulse per forward step; drives a counter's up input directly.
REQ-010 down  output  1  one-cycle pulse per reverse step; drives a counter's down input directly.
REQ-011 dir  output  1  last valid direction: 1 = forward, 0 = reverse.
REQ-012 err  output  1  sticky flag set on an illegal phase jump.

Function
REQ-013 a_in and b_in SHALL each pass through SYNC_STAGES flops before any other use.
REQ-014 The phase SHALL be {A,B}; the forward sequence is 00->01->11->10->00 and the reverse sequence is its inverse.
REQ-015 The block SHALL hold a registered previous phase and compare each new accepted phase against it every cycle.
REQ-016 A forward step with enable=1 SHALL assert up for exactly one cycle on the edge following acceptance.
REQ-017 A reverse step with enable=1 SHALL assert down for exactly one cycle on the edge following acceptance.
REQ-018 An unchanged phase SHALL produce no pulse.
REQ-019 up and down SHALL never be high in the same cycle.
REQ-020 A double step (00<->11 or 01<->10) with enable=1 SHALL produce no pulse, SHALL set err, and SHALL still update the previous phase to the new value.
REQ-021 dir SHALL update on the same edge as up or down (1 with up, 0 with down) and SHALL hold otherwise, including across illegal jumps.
REQ-022 With enable=0, the previous phase SHALL keep tracking; up, down, dir and err SHALL not change.
REQ-023 err_clr=1 SHALL clear err on the next edge.
REQ-024 If err_clr and an illegal jump occur in the same cycle, err SHALL be set (set wins).
REQ-025 Latency without filter SHALL be SYNC_STAGES+1 cycles from a pin change to the up/down pulse.
REQ-026 The block SHALL detect one step per accepted phase change; input toggling faster than the acceptance rate is out of spec and SHALL be reported via err only if it appears as a double step.

Reset
REQ-027 During reset: synchronizer flops = 0; filter counters = 0; up = 0, down = 0, dir = 1, err = 0.
REQ-028 The first accepted phase after reset release SHALL load the previous phase without generating a pulse or an error; this holds for any input level, including 11.
REQ-029 Reset asserted mid-operation SHALL abort any pending pulse immediately, with no pulse emitted after release.

Configuration
REQ-030 Macro QDEC_FILTER_EN: when defined, each synchronized channel SHALL be accepted only after holding the same level for FILTER_LEN consecutive cycles; a level change restarts that channel's count; latency becomes SYNC_STAGES+FILTER_LEN+1 cycles.
REQ-031 When QDEC_FILTER_EN is undefined, the synchronized levels SHALL be accepted directly, the filter logic SHALL be absent, and FILTER_LEN SHALL be ignored.

Verification (SYNC_STAGES=2; FILTER_LEN=4 in filter builds)
REQ-032 Reset, then inputs 00,01,11,10,00 with each level held 8 cycles -> 4 up pulses, each 3 cycles after its edge; dir=1; err=0.
REQ-033 Reverse sequence 00,10,11,01,00 -> 4 down pulses; dir=0 after the first pulse; no up pulse.
REQ-034 Jump 00->11 with enable=1 -> no pulse, err=1; err_clr pulse -> err=0; illegal jump coincident with err_clr -> err stays 1.
REQ-035 Inputs held at 11 through reset release -> no pulse and no err; next input 10 -> 1 up pulse.
REQ-036 enable=0 while stepping forward 2 phases, then enable=1 and 1 more forward step -> exactly 1 up pulse.
REQ-037 Filter build: 2-cycle glitch on a_in -> no pulse; a_in change held 4 cycles -> 1 pulse, 7 cycles after the edge.
